// File: rtl/main_fsm_pkg.sv
// Shared control package: state encodings, datapath mux codes and the
// control-word layout used by main_fsm and the multicycle datapath.
package main_fsm_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  // Instruction class (Instr[27:26])
  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
  } ctrl_t;

endpackage

// File: rtl/main_fsm.sv
// Multicycle main controller: Moore FSM sequencing fetch/decode/execute and
// decoding the datapath control word purely from the current state.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int unsigned STATE_W = main_fsm_pkg::STATE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic               ALUOp,
  output logic [STATE_W-1:0] State
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  // Funct[4:1] belong to the ALU decoder, not to sequencing
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_nxt = S_FETCH;
    ctrl      = '0;
    case (state)
      S_FETCH: begin
        state_nxt      = S_DECODE;
        ctrl.irwrite   = 1'b1;
        ctrl.nextpc    = 1'b1;
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURES;
      end
      S_DECODE: begin
        case (Op)
          OP_MEM:   state_nxt = S_MEMADR;
          OP_DP:    state_nxt = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:    state_nxt = S_BRANCH;
          OP_UNDEF: state_nxt = S_UNKNOWN;
          default:  state_nxt = S_UNKNOWN;
        endcase
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURES;
      end
      S_MEMADR: begin
        state_nxt    = Funct[0] ? S_MEMRD : S_MEMWR;
        ctrl.alusrca = SRCA_REG;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        state_nxt      = S_MEMWB;
        ctrl.adrsrc    = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
      end
      S_MEMWR: begin
        state_nxt      = S_FETCH;
        ctrl.adrsrc    = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.memw      = 1'b1;
      end
      S_MEMWB: begin
        state_nxt      = S_FETCH;
        ctrl.resultsrc = RES_DATA;
        ctrl.regw      = 1'b1;
      end
      S_EXECUTER: begin
        state_nxt    = S_ALUWB;
        ctrl.alusrca = SRCA_REG;
        ctrl.alusrcb = SRCB_WD;
        ctrl.aluop   = 1'b1;
      end
      S_EXECUTEI: begin
        state_nxt    = S_ALUWB;
        ctrl.alusrca = SRCA_REG;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = 1'b1;
      end
      S_ALUWB: begin
        state_nxt      = S_FETCH;
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regw      = 1'b1;
      end
      S_BRANCH: begin
        state_nxt      = S_FETCH;
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_IMM;
        ctrl.resultsrc = RES_ALURES;
        ctrl.branch    = 1'b1;
      end
      S_UNKNOWN: state_nxt = S_FETCH;
      // Illegal encodings recover to FETCH with every strobe low
      default:   state_nxt = S_FETCH;
    endcase
  end

  assign IRWrite   = ctrl.irwrite;
  assign AdrSrc    = ctrl.adrsrc;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign ResultSrc = ctrl.resultsrc;
  assign NextPC    = ctrl.nextpc;
  assign RegW      = ctrl.regw;
  assign MemW      = ctrl.memw;
  assign Branch    = ctrl.branch;
  assign ALUOp     = ctrl.aluop;
  assign State     = STATE_W'(state);

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameter: STATE_W, default 4, width of the state register and of the state debug port.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Op  input  2  Instr[27:26], the instruction class.
REQ-005 Funct  input  6  Instr[25:20]; bit5 = I (immediate), bit0 = L (load) / S.
REQ-006 IRWrite  output  1  enables the instruction register load.
REQ-007 AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
REQ-008 ALUSrcA  output  2  ALU A select: 00 = register A, 10 = PC; 01 and 11 are never driven.
REQ-009 ALUSrcB  output  2  ALU B select: 00 = WriteData, 01 = ExtImm, 10 = constant 4.
REQ-010 ResultSrc  output  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-011 NextPC  output  1  requests a PC update (PC <= Result).
REQ-012 RegW  output  1  unconditioned register-file write request.
REQ-013 MemW  output  1  unconditioned memory write request.
REQ-014 Branch  output  1  branch request; conditional logic combines it downstream.
REQ-015 ALUOp  output  1  1 = ALU decoder uses Funct; 0 = force ADD.
REQ-016 State  output  STATE_W  current state encoding, for debug and bench observation only.

Function
REQ-017 The block SHALL be a Moore machine: every output is a pure decode of the state register, with no Op/Funct term.
REQ-018 The state set SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH and UNKNOWN.
REQ-019 Transitions SHALL be one per clk edge:
- FETCH goes to DECODE.
- MEMRD goes to MEMWB.
- EXECUTER and EXECUTEI go to ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH and UNKNOWN go to FETCH.
REQ-020 DECODE SHALL branch on Op and Funct:
- Op=01 goes to MEMADR.
- Op=00 with Funct[5]=0 goes to EXECUTER.
- Op=00 with Funct[5]=1 goes to EXECUTEI.
- Op=10 goes to BRANCH.
- Op=11 goes to UNKNOWN.
REQ-021 MEMADR SHALL go to MEMRD when Funct[0]=1 and to MEMWR when Funct[0]=0; Op and Funct are sampled in the cycle of the decision.
REQ-022 FETCH outputs: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=10, ALUSrcB=10, ResultSrc=10, ALUOp=0.
REQ-023 DECODE outputs: ALUSrcA=10, ALUSrcB=10, ResultSrc=10, ALUOp=0.
REQ-024 MEMADR outputs: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
REQ-025 MEMRD outputs: AdrSrc=1, ResultSrc=00.
REQ-026 MEMWR outputs: AdrSrc=1, ResultSrc=00, MemW=1.
REQ-027 MEMWB outputs: ResultSrc=01, RegW=1.
REQ-028 EXECUTER outputs: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
REQ-029 EXECUTEI outputs: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
REQ-030 ALUWB outputs: ResultSrc=00, RegW=1.
REQ-031 BRANCH outputs: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1.
REQ-032 UNKNOWN SHALL drive every output to 0, so no write strobe is asserted.
REQ-033 Any output not listed for a state SHALL be 0.
REQ-034 An illegal state encoding SHALL go to FETCH on the next edge and drive all outputs to 0.
REQ-035 Instruction latency SHALL be: load 5 cycles, store 4, data-processing 4, branch 3, undefined 3.
REQ-036 No write strobe (IRWrite, RegW, MemW, NextPC, Branch) SHALL ever be asserted in two consecutive states of one instruction, except where this table asserts it.

Reset
REQ-037 Asserting reset SHALL force the state to FETCH immediately, without waiting for clk, including mid-instruction.
REQ-038 While reset is high, outputs SHALL show the FETCH decode; datapath registers are held by their own resets.
REQ-039 After reset deasserts, the first clk edge SHALL move the state to DECODE.

Structure
REQ-040 The state encodings, the ALUSrcA/ALUSrcB/ResultSrc code constants and STATE_W SHALL live in a shared control package used by main_fsm and the datapath.
REQ-041 The block SHALL contain a state register with async reset and a combinational next-state/output decode; no sub-module is required.

Verification
REQ-042 Reset is pulsed while in MEMWR (MemW=1) -> State=FETCH and MemW=0 within the same cycle, before any clk edge.
REQ-043 LDR (Op=01, Funct=011001) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegW=1 only in the cycle-5 state (MEMWB), ResultSrc=01.
REQ-044 STR (Op=01, Funct=011000) -> states FETCH, DECODE, MEMADR, MEMWR, FETCH; MemW=1 only in MEMWR, AdrSrc=1.
REQ-045 ADD immediate (Op=00, Funct=101000), then ADD register (Funct=001000) -> EXECUTEI with ALUSrcB=01, then EXECUTER with ALUSrcB=00; ALUOp=1 and ALUWB follows in both.
REQ-046 B (Op=10) -> FETCH, DECODE, BRANCH, FETCH; Branch=1 with ALUSrcA=10 and ALUSrcB=01 in BRANCH.
REQ-047 Op=11 -> UNKNOWN with all outputs 0, then FETCH on the next edge.
